doa_estimator: RTL and testbench

//  Parametrised successor to the single-bin weight stage; sits after the frequency detector.
//  On detectdone, reads the peak FFT bin (maxbin) from all NCH channel RAMs.

---
 rtl/doa_estimator.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_doa_estimator.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/doa_estimator.sv
`default_nettype none
// ============================================================================
//  Module   : doa_estimator
//  Purpose  : Direction-of-arrival estimator. On detectdone, reads the peak
//             FFT bin from NCH channel RAMs and sums the adjacent-channel
//             cross products. It then takes atan2 of the sum by CORDIC
//             vectoring and divides the angle by the bin index. The result is
//             a signed DOA angle clamped to +/-90 degrees.
//  Ports    : clk, reset (sync, active-high)
//             detectdone/maxbin - start pulse and peak bin index
//             rdaddr/ramq       - per-channel RAM address out / data in (ch0 LSBs)
//             busy/done         - operation in progress / 1-cycle completion
//             phase             - signed Q8.8 degrees
//             doa               - signed degrees, -90..+90
//  Options  : DOA_AVG_EN - when defined, doa is the running average of the
//             previous doa and the new clamped quotient.
//  Revision : 1.0 - initial release
// ============================================================================
module doa_estimator #(
    parameter int NCH       = 4,
    parameter int DW        = 24,
    parameter int AW        = 10,
    parameter int RAM_LAT   = 2,
    parameter int CORDIC_IT = 12,
    parameter int K_DOA     = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                detectdone,
    input  logic [AW-1:0]       maxbin,
    output logic [NCH*AW-1:0]   rdaddr,
    input  logic [NCH*DW-1:0]   ramq,
    output logic                busy,
    output logic                done,
    output logic [15:0]         phase,
    output logic [7:0]          doa
);

    localparam int HW    = DW / 2;
    localparam int ACC_W = DW + 4;
    // CORDIC datapath: room for a negated accumulator, sqrt(2) and CORDIC gain.
    localparam int XW    = DW + 6;
    // Angle accumulator: +/-180 deg plus CORDIC overshoot in Q8.8.
    localparam int ZW    = 18;
    localparam int PW    = ZW + 16;
    localparam int RW    = AW + 9;
    localparam int IW    = $clog2(NCH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_CAPT  = 3'd2;
    localparam logic [2:0] S_XCORR = 3'd3;
    localparam logic [2:0] S_ATAN  = 3'd4;
    localparam logic [2:0] S_DIV   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic signed [ZW-1:0] C_Z90  = 18'sd23040;
    localparam logic signed [ZW-1:0] C_PMAX = 18'sd32767;
    localparam logic signed [ZW-1:0] C_PMIN = -18'sd32768;
    localparam logic [15:0]          C_K    = 16'(K_DOA);

    // atan(2^-i) in Q8.8 degrees, rounded to nearest.
    function automatic logic signed [ZW-1:0] atan_tab(input logic [7:0] i);
        case (i)
            8'd0:    atan_tab = 18'sd11520;
            8'd1:    atan_tab = 18'sd6801;
            8'd2:    atan_tab = 18'sd3593;
            8'd3:    atan_tab = 18'sd1824;
            8'd4:    atan_tab = 18'sd916;
            8'd5:    atan_tab = 18'sd458;
            8'd6:    atan_tab = 18'sd229;
            8'd7:    atan_tab = 18'sd115;
            8'd8:    atan_tab = 18'sd57;
            8'd9:    atan_tab = 18'sd29;
            8'd10:   atan_tab = 18'sd14;
            8'd11:   atan_tab = 18'sd7;
            8'd12:   atan_tab = 18'sd4;
            8'd13:   atan_tab = 18'sd2;
            8'd14:   atan_tab = 18'sd1;
            default: atan_tab = 18'sd0;
        endcase
    endfunction

    logic [2:0]              r_state;
    logic [7:0]              r_cnt;
    logic [AW-1:0]           r_mb;
    logic signed [HW-1:0]    r_re [NCH];
    logic signed [HW-1:0]    r_im [NCH];
    logic signed [ACC_W-1:0] r_sre, r_sim;
    logic signed [XW-1:0]    r_x, r_y;
    logic signed [ZW-1:0]    r_z;
    logic [RW-1:0]           r_rem;
    logic [14:0]             r_q;
`ifdef DOA_AVG_EN
    logic                    r_have_prev;
`endif

    // ---------------------------------------------------------------- control
    logic w_last;
    always_comb begin
        w_last = 1'b0;
        case (r_state)
            S_ADDR:  w_last = (r_cnt == 8'(RAM_LAT - 1));
            S_CAPT:  w_last = 1'b1;
            S_XCORR: w_last = (r_cnt == 8'(NCH - 2));
            S_ATAN:  w_last = (r_cnt == 8'(CORDIC_IT - 1));
            S_DIV:   w_last = (r_cnt == 8'd15);
            default: w_last = 1'b0;
        endcase
    end

    always_comb begin
        rdaddr = '0;
        if (r_state == S_ADDR || r_state == S_CAPT)
            rdaddr = {NCH{r_mb}};
    end

    // ------------------------------------------------ cross products, X1*conj(X0)
    logic [IW-1:0]         w_i0, w_i1;
    logic signed [2*HW-1:0] w_ac, w_bd, w_bc, w_ad;
    always_comb begin
        w_i0 = r_cnt[IW-1:0];
        w_i1 = w_i0 + 1'b1;
        w_ac = r_re[w_i1] * r_re[w_i0];
        w_bd = r_im[w_i1] * r_im[w_i0];
        w_bc = r_im[w_i1] * r_re[w_i0];
        w_ad = r_re[w_i1] * r_im[w_i0];
    end

    // ------------------------------------------------------ CORDIC vectoring
    // The first iteration takes its input straight from the accumulator after
    // quadrant pre-rotation, so no extra cycle is spent on the pre-rotation.
    // Once y is exactly zero the residual angle is exactly zero, so the vector
    // is frozen; this makes real-axis and zero inputs give an exact 0.
    logic signed [XW-1:0] w_xi, w_yi, w_xs, w_ys, w_xn, w_yn;
    logic signed [ZW-1:0] w_zi, w_zn, w_ang;
    always_comb begin
        w_xi = r_x;
        w_yi = r_y;
        w_zi = r_z;
        if (r_cnt == 8'd0) begin
            if (r_sre < 0) begin
                if (r_sim >= 0) begin
                    w_xi = XW'(r_sim);
                    w_yi = -XW'(r_sre);
                    w_zi = C_Z90;
                end else begin
                    w_xi = -XW'(r_sim);
                    w_yi = XW'(r_sre);
                    w_zi = -C_Z90;
                end
            end else begin
                w_xi = XW'(r_sre);
                w_yi = XW'(r_sim);
                w_zi = '0;
            end
        end
        w_xs  = w_xi >>> r_cnt;
        w_ys  = w_yi >>> r_cnt;
        w_ang = atan_tab(r_cnt);
        if (w_yi == 0) begin
            w_xn = w_xi;
            w_yn = w_yi;
            w_zn = w_zi;
        end else if (!w_yi[XW-1]) begin
            w_xn = w_xi + w_ys;
            w_yn = w_yi - w_xs;
            w_zn = w_zi + w_ang;
        end else begin
            w_xn = w_xi - w_ys;
            w_yn = w_yi + w_xs;
            w_zn = w_zi - w_ang;
        end
    end

    // -------------------------------------------------- restoring magnitude divide
    // |angle|*K is divided by 256*mb. If the 16-bit quotient would overflow,
    // the result saturates anyway, so the overflow test only feeds the clamp.
    // That lets the remainder start from the upper product bits, and only the
    // low 16 bits are shifted in, one per cycle. The divide uses the
    // full-precision angle, before phase is clamped to the 16-bit range.
    logic                    w_neg, w_ovf, w_bit, w_qbit;
    logic [ZW-1:0]           w_zmag;
    logic [PW-1:0]           w_prod;
    logic [15:0]             w_low, w_qmag;
    logic [3:0]              w_bidx;
    logic [AW+7:0]           w_d;
    logic [RW-1:0]           w_rem_in, w_t, w_rem_n;
    logic [6:0]              w_mag;
    logic signed [7:0]       w_qsat, w_doa_n;
    logic [15:0]             w_phase_sat;
    always_comb begin
        w_neg    = r_z[ZW-1];
        w_zmag   = w_neg ? -r_z : r_z;
        w_prod   = PW'(w_zmag) * PW'(C_K);
        w_d      = {r_mb, 8'h00};
        w_ovf    = (RW'(w_prod[PW-1:16]) >= RW'(w_d));
        w_rem_in = (r_cnt == 8'd0) ? RW'(w_prod[PW-1:16]) : r_rem;
        w_bidx   = 4'd15 - r_cnt[3:0];
        w_low    = w_prod[15:0];
        w_bit    = w_low[w_bidx];
        w_t      = {w_rem_in[RW-2:0], w_bit};
        w_qbit   = (w_t >= RW'(w_d));
        w_rem_n  = w_qbit ? (w_t - RW'(w_d)) : w_t;
        w_qmag   = {r_q, w_qbit};
        w_mag    = (w_ovf || w_qmag > 16'd90) ? 7'd90 : w_qmag[6:0];
        if (r_mb == '0)
            w_qsat = 8'sd0;
        else if (w_neg)
            w_qsat = -$signed({1'b0, w_mag});
        else
            w_qsat = $signed({1'b0, w_mag});

        if (r_z > C_PMAX)
            w_phase_sat = 16'h7FFF;
        else if (r_z < C_PMIN)
            w_phase_sat = 16'h8000;
        else
            w_phase_sat = r_z[15:0];
    end

`ifdef DOA_AVG_EN
    logic signed [8:0] w_sum, w_avg;
    always_comb begin
        w_sum = 9'(w_qsat) + 9'($signed(doa));
        w_avg = w_sum >>> 1;
        if (!r_have_prev)
            w_doa_n = w_qsat;
        else if (w_avg > 9'sd90)
            w_doa_n = 8'sd90;
        else if (w_avg < -9'sd90)
            w_doa_n = -8'sd90;
        else
            w_doa_n = w_avg[7:0];
    end
`else
    always_comb w_doa_n = w_qsat;
`endif

    // ------------------------------------------------------------- sequencer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mb    <= '0;
            r_sre   <= '0;
            r_sim   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            phase   <= '0;
            doa     <= '0;
            for (int k = 0; k < NCH; k++) begin
                r_re[k] <= '0;
                r_im[k] <= '0;
            end
`ifdef DOA_AVG_EN
            r_have_prev <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (detectdone) begin
                        r_mb    <= maxbin;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    r_cnt <= w_last ? 8'd0 : r_cnt + 8'd1;
                    if (w_last)
                        r_state <= S_CAPT;
                end
                S_CAPT: begin
                    for (int k = 0; k < NCH; k++) begin
                        r_re[k] <= ramq[k*DW + DW - 1 -: HW];
                        r_im[k] <= ramq[k*DW + HW - 1 -: HW];
                    end
                    r_sre   <= '0;
                    r_sim   <= '0;
                    r_cnt   <= '0;
                    r_state <= S_XCORR;
                end
                S_XCORR: begin
                    r_sre <= r_sre + ACC_W'(w_ac) + ACC_W'(w_bd);
                    r_sim <= r_sim + ACC_W'(w_bc) - ACC_W'(w_ad);
                    r_cnt <= w_last ? 8'd0 : r_cnt + 8'd1;
                    if (w_last)
                        r_state <= S_ATAN;
                end
                S_ATAN: begin
                    r_x   <= w_xn;
                    r_y   <= w_yn;
                    r_z   <= w_zn;
                    r_cnt <= w_last ? 8'd0 : r_cnt + 8'd1;
                    if (w_last)
                        r_state <= S_DIV;
                end
                S_DIV: begin
                    r_rem <= w_rem_n;
                    r_q   <= w_qmag[14:0];
                    r_cnt <= w_last ? 8'd0 : r_cnt + 8'd1;
                    if (w_last) begin
                        phase   <= w_phase_sat;
                        doa     <= w_doa_n;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_DONE;
`ifdef DOA_AVG_EN
                        r_have_prev <= 1'b1;
`endif
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_doa_estimator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_doa_estimator
//  Purpose  : Self-checking bench for doa_estimator. A RAM model returns the
//             channel samples only at the requested bin. Expected phase and
//             doa come from floating-point atan2 of the cross-product sum.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_doa_estimator;

    localparam int    NCH = 4;
    localparam int    DW  = 24;
    localparam int    AW  = 10;
    localparam int    LAT = 2 + NCH + 12 + 17;
    localparam real   PI  = 3.14159265358979323846;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              detectdone = 1'b0;
    logic [AW-1:0]     maxbin = '0;
    logic [NCH*AW-1:0] rdaddr;
    logic [NCH*DW-1:0] ramq = '0;
    logic              busy, done;
    logic [15:0]       phase;
    logic [7:0]        doa;

    int n_chk  = 0;
    int n_pass = 0;
    int dre [NCH];
    int dim [NCH];
    int m_prev = 0;
    int m_have = 0;
    logic [AW-1:0]     cur_bin = '0;
    logic [NCH*DW-1:0] ram_p1 = '0;
    logic [NCH*DW-1:0] ram_w;

    always #5 clk = ~clk;

    doa_estimator #(
        .NCH(NCH), .DW(DW), .AW(AW), .RAM_LAT(2), .CORDIC_IT(12), .K_DOA(128)
    ) u_dut (
        .clk(clk), .reset(reset), .detectdone(detectdone), .maxbin(maxbin),
        .rdaddr(rdaddr), .ramq(ramq), .busy(busy), .done(done),
        .phase(phase), .doa(doa)
    );

    // Two-cycle-latency RAM: valid samples only at cur_bin, junk elsewhere.
    always @(posedge clk) begin
        for (int ch = 0; ch < NCH; ch++) begin
            if (rdaddr[ch*AW +: AW] == cur_bin)
                ram_w[ch*DW +: DW] = {12'(dre[ch]), 12'(dim[ch])};
            else
                ram_w[ch*DW +: DW] = 24'h5A3C71 ^ 24'(ch * 7919);
        end
        ram_p1 <= ram_w;
        ramq   <= ram_p1;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic set_polar(input real a, input real th0, input real step);
        for (int i = 0; i < NCH; i++) begin
            real t;
            t = (th0 + i * step) * PI / 180.0;
            dre[i] = rnd(a * $cos(t));
            dim[i] = rnd(a * $sin(t));
        end
    endtask

    task automatic set_zero();
        for (int i = 0; i < NCH; i++) begin
            dre[i] = 0;
            dim[i] = 0;
        end
    endtask

    // Angle of sum over i of X[i+1]*conj(X[i]), in degrees.
    function automatic real model_deg();
        longint sr, si;
        sr = 0;
        si = 0;
        for (int i = 0; i < NCH - 1; i++) begin
            sr += longint'(dre[i+1]) * dre[i] + longint'(dim[i+1]) * dim[i];
            si += longint'(dim[i+1]) * dre[i] - longint'(dre[i+1]) * dim[i];
        end
        if (sr == 0 && si == 0)
            return 0.0;
        return $atan2(real'(si), real'(sr)) * 180.0 / PI;
    endfunction

    function automatic int model_q(input real deg, input int bin);
        int q;
        if (bin == 0)
            return 0;
        q = $rtoi(deg * 128.0 / bin);
        if (q > 90)  q = 90;
        if (q < -90) q = -90;
        return q;
    endfunction

    // Reported doa given the new clamped quotient (running average if enabled).
    function automatic int exp_doa(input int q);
        int r;
`ifdef DOA_AVG_EN
        r = m_have ? ((m_prev + q) >>> 1) : q;
`else
        r = q;
`endif
        m_prev = r;
        m_have = 1;
        return r;
    endfunction

    task automatic run_op(input logic [AW-1:0] bin, input int inj, input int rst_at,
                          output int lat, output int ndone);
        cur_bin = bin;
        lat     = -1;
        ndone   = 0;
        @(posedge clk);
        #1;
        maxbin     = bin;
        detectdone = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            detectdone = 1'b0;
            if (c == 1) begin
                check("rdaddr_addr", longint'(rdaddr), longint'({NCH{bin}}));
                check("busy_start", longint'(busy), 1);
            end
            if (c == 3 && rst_at == 0)
                check("rdaddr_capt", longint'(rdaddr), longint'({NCH{bin}}));
            if (c == 4)
                check("rdaddr_xcorr", longint'(rdaddr), 0);
            if (rst_at > 0 && c == rst_at + 1) begin
                reset = 1'b0;
                check("rst_busy", longint'(busy), 0);
                check("rst_done", longint'(done), 0);
                check("rst_doa", longint'(doa), 0);
                check("rst_phase", longint'(phase), 0);
                m_have = 0;
                m_prev = 0;
            end
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = c;
                    check("busy_at_done", longint'(busy), 0);
                end
            end
            if (c == inj) begin
                detectdone = 1'b1;
                maxbin     = bin ^ 10'h155;
            end
            if (c == rst_at)
                reset = 1'b1;
        end
    endtask

    initial begin
        int  lat, nd, e;
        real deg;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", longint'(busy), 0);
        check("reset_done", longint'(done), 0);
        check("reset_phase", longint'(phase), 0);
        check("reset_doa", longint'(doa), 0);
        check("reset_rdaddr", longint'(rdaddr), 0);
        reset = 1'b0;

        // Identical channels: zero phase difference.
        set_polar(1000.0, 0.0, 0.0);
        run_op(10'd100, 0, 0, lat, nd);
        check("t1_latency", lat, LAT);
        check("t1_ndone", nd, 1);
        check("t1_phase", longint'($signed(phase)), 0);
        check("t1_doa", longint'($signed(doa)), exp_doa(0));

        // +30 deg per channel, bin 64 -> 60 deg.
        set_polar(1000.0, 0.0, 30.0);
        run_op(10'd64, 0, 0, lat, nd);
        check("t2_latency", lat, LAT);
        check("t2_phase_tol", longint'(iabs(int'($signed(phase)) - 7680) <= 26), 1);
        check("t2_doa", longint'($signed(doa)), exp_doa(60));
        repeat (5) @(posedge clk);
        #1;
        check("t2_doa_hold", longint'($signed(doa)), m_prev);

        // Follow-up with zero-difference data: average or replace.
        set_polar(1000.0, 0.0, 0.0);
        run_op(10'd100, 0, 0, lat, nd);
        check("t6_doa", longint'($signed(doa)), exp_doa(0));

        // -30 deg per channel, bin 32 -> -120 clamps to -90.
        set_polar(1000.0, 0.0, -30.0);
        run_op(10'd32, 0, 0, lat, nd);
        check("t3_phase_tol", longint'(iabs(int'($signed(phase)) + 7680) <= 26), 1);
        check("t3_doa", longint'($signed(doa)), exp_doa(-90));

        // Bin 0: divide skipped, timing unchanged.
        set_polar(1000.0, 0.0, 30.0);
        run_op(10'd0, 0, 0, lat, nd);
        check("t4_latency", lat, LAT);
        check("t4_doa", longint'($signed(doa)), exp_doa(0));

        // All-zero samples.
        set_zero();
        run_op(10'd5, 0, 0, lat, nd);
        check("t4z_phase", longint'($signed(phase)), 0);
        check("t4z_doa", longint'($signed(doa)), exp_doa(0));

        // Second detectdone while busy is ignored.
        set_polar(1000.0, 0.0, 30.0);
        run_op(10'd64, 10, 0, lat, nd);
        check("t5_ndone", nd, 1);
        check("t5_latency", lat, LAT);
        check("t5_doa", longint'($signed(doa)), exp_doa(60));

        // Reset mid-operation aborts without a done pulse.
        run_op(10'd64, 0, 20, lat, nd);
        check("t5r_ndone", nd, 0);
        run_op(10'd64, 0, 0, lat, nd);
        check("t5n_latency", lat, LAT);
        check("t5n_doa", longint'($signed(doa)), exp_doa(60));

        // Randomized phase steps, amplitudes and bins.
        for (int n = 0; n < 16; n++) begin
            real a, th0, step;
            int  bin, ep;
            a    = 800.0 + real'($urandom_range(0, 1200));
            th0  = real'($urandom_range(0, 359));
            step = real'($urandom_range(0, 2400)) / 10.0 - 120.0;
            bin  = int'($urandom_range(8, 1023));
            set_polar(a, th0, step);
            run_op(AW'(bin), 0, 0, lat, nd);
            deg = model_deg();
            ep  = rnd(deg * 256.0);
            e   = exp_doa(model_q(deg, bin));
            check("rnd_latency", lat, LAT);
            check("rnd_phase_tol", longint'(iabs(int'($signed(phase)) - ep) <= 26), 1);
            check("rnd_doa_tol", longint'(iabs(int'($signed(doa)) - e) <= 1), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
